// File: rtl/wb_select_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_select_pipe
// Brief    : Registered write-back source select with load-data wait/timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_select_pipe #(
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 2,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [REG_ADDR_W-1:0]     in_rd,
    input  logic                      in_wen,
    input  logic                      in_is_load,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      wb_valid,
    output logic                      wb_en,
    output logic [REG_ADDR_W-1:0]     wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      sel_err,
    output logic                      timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_wen;
    logic                  r_wb_valid;
    logic                  r_wb_en;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0]     r_wb_data;
    logic                  r_sel_err;
    logic                  r_timeout;

    logic [DATA_W-1:0]     w_sel_data;
    logic                  w_sel_ok;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_expire;

    // Out-of-range selects (NUM_SRC not a power of two) leave w_sel_ok low.
    always_comb begin
        w_sel_data = '0;
        w_sel_ok   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = in_src[k*DATA_W +: DATA_W];
                w_sel_ok   = 1'b1;
            end
        end
    end

    // Expiry is judged on the count this cycle would reach, so a wait lasts
    // exactly TIMEOUT cycles; a same-cycle mem_rvalid takes priority.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_expire  = !mem_rvalid && (w_cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_wen      <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_sel_err  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_en    <= 1'b0;
            r_sel_err  <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_is_load) begin
                            r_state <= S_WAIT;
                            r_cnt   <= '0;
                            r_rd    <= in_rd;
                            r_wen   <= in_wen;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_wb_addr  <= in_rd;
                            if (w_sel_ok) begin
                                r_wb_data <= w_sel_data;
                                r_wb_en   <= in_wen && (in_rd != '0);
                            end else begin
                                r_wb_data <= '0;
                                r_sel_err <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_state    <= S_IDLE;
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= r_rd;
                        r_wb_data  <= mem_rdata;
                        r_wb_en    <= r_wen && (r_rd != '0);
                    end else if (w_expire) begin
                        // Timed-out load reports its destination but never writes.
                        r_state    <= S_IDLE;
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= r_rd;
                        r_wb_data  <= '0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign wb_valid = r_wb_valid;
    assign wb_en    = r_wb_en;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign sel_err  = r_sel_err;
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
Parametrised, registered write-back select stage for the KGPminiRISC datapath, sitting between EX/MEM and the register file.
- Picks one of NUM_SRC result sources (ALU result, memory load data, PC+4, immediate, ...) and registers it with the destination register address and write enable.
- Handles loads whose data returns later: stalls upstream, waits for the memory response with a bounded timeout, then writes back.

Parameters:
DATA_W, 32, width of each source and of write-back data
NUM_SRC, 4, number of selectable sources (2..2**SEL_W)
SEL_W, 2, width of select field
REG_ADDR_W, 5, register-file address width
TIMEOUT, 15, max cycles spent waiting for mem_rvalid (1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream presents a write-back request
in_ready  output  1  stage can accept a request this cycle
in_sel  input  SEL_W  source select; index k picks in_src[k*DATA_W +: DATA_W]
in_src  input  NUM_SRC*DATA_W  flattened source vector, source 0 in LSBs
in_rd  input  REG_ADDR_W  destination register
in_wen  input  1  request intends a register write
in_is_load  input  1  data comes from mem_rdata, in_sel ignored
mem_rvalid  input  1  load data valid
mem_rdata  input  DATA_W  load data
wb_valid  output  1  one-cycle pulse, write-back result present
wb_en  output  1  register-file write enable (qualified by wb_valid)
wb_addr  output  REG_ADDR_W  register-file write address
wb_data  output  DATA_W  register-file write data
sel_err  output  1  one-cycle pulse, in_sel >= NUM_SRC on an accepted request
timeout  output  1  one-cycle pulse, load wait expired

Behaviour:
- Reset (async, rst_n=0): state IDLE, wait counter 0, wb_valid=0, wb_en=0, wb_addr=0, wb_data=0, sel_err=0, timeout=0. in_ready=1 once rst_n=1.
- States: IDLE, WAIT_MEM.
- in_ready = (state==IDLE). A request is accepted when in_valid && in_ready.
- IDLE, accept, in_is_load=0: next cycle wb_valid=1, wb_data=selected source, wb_addr=in_rd, wb_en=in_wen && (in_rd!=0). Latency 1 cycle. Throughput 1 per cycle.
- in_sel >= NUM_SRC (non-load): wb_data=0, wb_en=0, wb_valid=1, sel_err=1, all in the same output cycle.
- IDLE, accept, in_is_load=1:
  - Capture in_rd and in_wen, go to WAIT_MEM, clear counter.
  - wb_valid=0 in the next cycle.
  - mem_rvalid in the acceptance cycle is ignored; data must arrive in WAIT_MEM.
- WAIT_MEM:
  - in_ready=0. Counter increments each cycle without mem_rvalid.
  - On mem_rvalid: next cycle wb_valid=1, wb_data=mem_rdata, captured address, wb_en=captured wen && addr!=0; state returns to IDLE.
  - If the counter reaches TIMEOUT with no mem_rvalid: next cycle wb_valid=1, wb_en=0, wb_data=0, timeout=1; state returns to IDLE.
  - mem_rvalid in the same cycle the counter reaches TIMEOUT: the data wins, timeout=0.
- mem_rvalid while IDLE: ignored, no output effect.
- wb_valid, sel_err, timeout are single-cycle pulses. wb_addr/wb_data hold their last value when wb_valid=0.
- Reset asserted in WAIT_MEM: abort immediately to IDLE, no write-back or timeout pulse produced.
- Counter width ceil(log2(TIMEOUT+1)), no wrap beyond TIMEOUT.

Test Plan:
- Reset then in_valid=1, in_sel=2, src2=0x0000_1004, in_rd=7, in_wen=1 -> next cycle wb_valid=1, wb_en=1, wb_addr=7, wb_data=0x0000_1004.
- Back-to-back non-load requests, sel 0,1,3 on consecutive cycles -> three consecutive wb_valid pulses, in_ready stays 1, data matches each source in order.
- Load to rd=5, mem_rvalid with 0xDEAD_BEEF after 3 cycles -> in_ready=0 for 3 cycles, then wb_valid=1, wb_addr=5, wb_data=0xDEAD_BEEF, wb_en=1.
- Load, no mem_rvalid for TIMEOUT=15 cycles -> timeout=1 with wb_valid=1, wb_en=0, in_ready back to 1. Repeat with mem_rvalid on the expiry cycle -> data written, timeout=0.
- NUM_SRC=3, in_sel=3 -> sel_err=1, wb_en=0, wb_data=0. Request with in_rd=0, in_wen=1 -> wb_valid=1, wb_en=0.
- Assert rst_n=0 mid-WAIT_MEM, then deliver mem_rvalid after release -> outputs zero, no write-back, state IDLE, in_ready=1.
